// File: rtl/axi_mem_pkg.sv
// Shared AXI4 encodings and channel bundles for the on-chip memory responder and the core's AXI arbiter.
// Pure type/constant container; no logic, no latency, no flow control of its own.
package axi_mem_pkg;

  localparam int AXI_DATA_W = 64;
  localparam int AXI_ADDR_W = 64;
  localparam int AXI_ID_W   = 8;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]     aw_id;
    logic [AXI_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_user;
    logic                    aw_valid;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [AXI_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    w_user;
    logic                    w_valid;
    logic                    b_ready;
    logic [AXI_ID_W-1:0]     ar_id;
    logic [AXI_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_user;
    logic                    ar_valid;
    logic                    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic                  aw_ready;
    logic                  w_ready;
    logic                  ar_ready;
    logic [AXI_ID_W-1:0]   b_id;
    logic [1:0]            b_resp;
    logic                  b_user;
    logic                  b_valid;
    logic [AXI_ID_W-1:0]   r_id;
    logic [AXI_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic                  r_user;
    logic                  r_valid;
  } axi_resp_t;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat AXI address for FIXED/INCR/WRAP bursts; purely combinational, zero latency.
// No flow control: caller decides when to advance.
module axi_burst_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [7:0]        len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] incr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  assign incr      = addr + (ADDR_W'(1) << size);
  assign wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
  assign wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);

  // Illegal WRAP lengths fall through to INCR behaviour.
  always_comb begin
    next_addr = incr;
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end else if ((burst == BURST_WRAP) && wrap_ok) begin
      next_addr = (addr & ~wrap_mask) | (incr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 subordinate backed by a sync-read byte-enabled RAM; first R beat 1 cycle after AR, B 1 cycle after last W.
// One burst in flight per direction; R fields hold while rready is low. AXI_MEM_RESP_DECERR_EN enables out-of-window DECERR.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int              DATA_W    = AXI_DATA_W,
  parameter int              ADDR_W    = AXI_ADDR_W,
  parameter int              ID_W      = AXI_ID_W,
  parameter int              MEM_BYTES = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h8000_0000
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  input  axi_req_t  axi_req_i,
  output axi_resp_t axi_resp_o
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int DEPTH = MEM_BYTES / NB;
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic       {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];

  logic ar_dec, aw_dec;
`ifdef AXI_MEM_RESP_DECERR_EN
  localparam int WIN_W = $clog2(MEM_BYTES);
  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return ((a - BASE_ADDR) >> WIN_W) == '0;
  endfunction
  assign ar_dec = !in_window(axi_req_i.ar_addr);
  assign aw_dec = !in_window(axi_req_i.aw_addr);
`else
  assign ar_dec = 1'b0;
  assign aw_dec = 1'b0;
`endif

  // ---------------- read channel ----------------
  r_state_e          r_state_q, r_state_d;
  logic [ID_W-1:0]   r_id_q;
  logic [ADDR_W-1:0] r_addr_q, r_next;
  logic [7:0]        r_len_q, r_cnt_q;
  logic [2:0]        r_size_q;
  logic [1:0]        r_burst_q;
  logic              r_dec_q, rd_dec;
  logic [DATA_W-1:0] r_data_q;
  logic              ar_ready, r_valid, r_last, ar_hs, r_hs, ram_re;
  logic [IDX_W-1:0]  ram_raddr;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_rd_addr (
    .addr(r_addr_q), .size(r_size_q), .len(r_len_q), .burst(r_burst_q), .next_addr(r_next)
  );

  assign r_last = (r_state_q == R_BURST) && (r_cnt_q == 8'd0);

  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    ar_hs     = 1'b0;
    r_hs      = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (axi_req_i.ar_valid) begin
          ar_hs     = 1'b1;
          r_state_d = R_BURST;
        end
      end
      R_BURST: begin
        r_valid = 1'b1;
        if (axi_req_i.r_ready) begin
          r_hs = 1'b1;
          if (r_last) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // The RAM output register only loads on a new read, which keeps rdata stable under backpressure.
  assign ram_re    = ar_hs || (r_hs && !r_last);
  assign ram_raddr = ar_hs ? word_idx(axi_req_i.ar_addr) : word_idx(r_next);
  assign rd_dec    = ar_hs ? ar_dec : r_dec_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_dec_q   <= 1'b0;
      r_data_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        r_id_q    <= axi_req_i.ar_id;
        r_addr_q  <= axi_req_i.ar_addr;
        r_len_q   <= axi_req_i.ar_len;
        r_cnt_q   <= axi_req_i.ar_len;
        r_size_q  <= axi_req_i.ar_size;
        r_burst_q <= axi_req_i.ar_burst;
        r_dec_q   <= ar_dec;
      end else if (r_hs && !r_last) begin
        r_cnt_q  <= r_cnt_q - 8'd1;
        r_addr_q <= r_next;
      end
      if (ram_re) r_data_q <= rd_dec ? '0 : mem[ram_raddr];
    end
  end

  // ---------------- write channel ----------------
  w_state_e          w_state_q, w_state_d;
  logic [ID_W-1:0]   w_id_q;
  logic [ADDR_W-1:0] w_addr_q, w_next;
  logic [7:0]        w_len_q, w_cnt_q;
  logic [2:0]        w_size_q;
  logic [1:0]        w_burst_q;
  logic              w_dec_q, w_err_q;
  logic              aw_ready, w_ready, b_valid, aw_hs, w_hs;
  logic [IDX_W-1:0]  ram_waddr;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_wr_addr (
    .addr(w_addr_q), .size(w_size_q), .len(w_len_q), .burst(w_burst_q), .next_addr(w_next)
  );

  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (axi_req_i.aw_valid) begin
          aw_hs     = 1'b1;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (axi_req_i.w_valid) begin
          w_hs = 1'b1;
          if (w_cnt_q == 8'd0) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_dec_q   <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        w_id_q    <= axi_req_i.aw_id;
        w_addr_q  <= axi_req_i.aw_addr;
        w_len_q   <= axi_req_i.aw_len;
        w_cnt_q   <= axi_req_i.aw_len;
        w_size_q  <= axi_req_i.aw_size;
        w_burst_q <= axi_req_i.aw_burst;
        w_dec_q   <= aw_dec;
        w_err_q   <= 1'b0;
      end else if (w_hs) begin
        if (axi_req_i.w_last != (w_cnt_q == 8'd0)) w_err_q <= 1'b1;
        if (w_cnt_q != 8'd0) begin
          w_cnt_q  <= w_cnt_q - 8'd1;
          w_addr_q <= w_next;
        end
      end
    end
  end

  assign ram_waddr = word_idx(w_addr_q);

  // Contents survive reset; a write racing a read of the same word leaves the read with old data.
  always_ff @(posedge clk_i) begin
    if (w_hs && !w_dec_q) begin
      for (int b = 0; b < NB; b++) begin
        if (axi_req_i.w_strb[b]) mem[ram_waddr][8*b +: 8] <= axi_req_i.w_data[8*b +: 8];
      end
    end
  end

  logic unused_user;
  assign unused_user = axi_req_i.aw_user ^ axi_req_i.w_user ^ axi_req_i.ar_user;

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.b_id     = w_id_q;
    axi_resp_o.b_resp   = w_dec_q ? RESP_DECERR : (w_err_q ? RESP_SLVERR : RESP_OKAY);
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.r_id     = r_id_q;
    axi_resp_o.r_data   = r_data_q;
    axi_resp_o.r_resp   = r_dec_q ? RESP_DECERR : RESP_OKAY;
    axi_resp_o.r_last   = r_last;
    axi_resp_o.r_valid  = r_valid;
  end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder; covers the DECERR build when AXI_MEM_RESP_DECERR_EN is defined.
module tb_axi_mem_responder;
  import axi_mem_pkg::*;

  logic      clk  = 1'b0;
  logic      rstn = 1'b0;
  axi_req_t  req;
  axi_resp_t resp;
  int        checks = 0;
  int        errors = 0;

  axi_mem_responder dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .axi_req_i (req),
    .axi_resp_o(resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    req.aw_id    = id;
    req.aw_addr  = addr;
    req.aw_len   = len;
    req.aw_size  = 3'd3;
    req.aw_burst = burst;
    req.aw_valid = 1'b1;
    tick();
    req.aw_valid = 1'b0;
    check("aw_ready_drops", resp.aw_ready, 1'b0);
    check("w_ready_after_aw", resp.w_ready, 1'b1);
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    req.w_data  = data;
    req.w_strb  = strb;
    req.w_last  = last;
    req.w_valid = 1'b1;
    tick();
    req.w_valid = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [7:0] id, input logic [1:0] rsp);
    check({tag, "_bvalid"}, resp.b_valid, 1'b1);
    check({tag, "_wready_low"}, resp.w_ready, 1'b0);
    check({tag, "_bid"}, resp.b_id, id);
    check({tag, "_bresp"}, resp.b_resp, rsp);
    req.b_ready = 1'b1;
    tick();
    req.b_ready = 1'b0;
    check({tag, "_b_done"}, resp.b_valid, 1'b0);
    check({tag, "_aw_ready_back"}, resp.aw_ready, 1'b1);
  endtask

  task automatic ar_send(input logic [7:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    req.ar_id    = id;
    req.ar_addr  = addr;
    req.ar_len   = len;
    req.ar_size  = 3'd3;
    req.ar_burst = burst;
    req.ar_valid = 1'b1;
    tick();
    req.ar_valid = 1'b0;
    check("ar_ready_drops", resp.ar_ready, 1'b0);
  endtask

  task automatic r_beat(input string tag, input logic [63:0] data, input logic last,
                        input logic [7:0] id, input logic [1:0] rsp);
    check({tag, "_rvalid"}, resp.r_valid, 1'b1);
    check({tag, "_rdata"}, resp.r_data, data);
    check({tag, "_rlast"}, resp.r_last, last);
    check({tag, "_rid"}, resp.r_id, id);
    check({tag, "_rresp"}, resp.r_resp, rsp);
    tick();
  endtask

  task automatic r_end(input string tag);
    check({tag, "_rvalid_low"}, resp.r_valid, 1'b0);
    check({tag, "_ar_ready_back"}, resp.ar_ready, 1'b1);
  endtask

  initial begin
    req = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ar_ready", resp.ar_ready, 1'b1);
    check("rst_aw_ready", resp.aw_ready, 1'b1);
    check("rst_w_ready", resp.w_ready, 1'b0);
    check("rst_r_valid", resp.r_valid, 1'b0);
    check("rst_b_valid", resp.b_valid, 1'b0);
    check("rst_r_last", resp.r_last, 1'b0);
    check("rst_r_id", resp.r_id, 8'h00);
    check("rst_b_id", resp.b_id, 8'h00);
    check("rst_r_resp", resp.r_resp, 2'b00);
    check("rst_b_resp", resp.b_resp, 2'b00);
    check("rst_r_data", resp.r_data, 64'h0);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    check("post_rst_ar_ready", resp.ar_ready, 1'b1);
    check("post_rst_aw_ready", resp.aw_ready, 1'b1);
    req.r_ready = 1'b1;

    // INCR write then read
    aw_send(8'h12, 64'h8000_0000, 8'd3, BURST_INCR);
    w_beat(64'h11, 8'hFF, 1'b0);
    w_beat(64'h22, 8'hFF, 1'b0);
    w_beat(64'h33, 8'hFF, 1'b0);
    w_beat(64'h44, 8'hFF, 1'b1);
    b_take("incr_wr", 8'h12, 2'b00);
    ar_send(8'h12, 64'h8000_0000, 8'd3, BURST_INCR);
    r_beat("incr_b0", 64'h11, 1'b0, 8'h12, 2'b00);
    r_beat("incr_b1", 64'h22, 1'b0, 8'h12, 2'b00);
    r_beat("incr_b2", 64'h33, 1'b0, 8'h12, 2'b00);
    r_beat("incr_b3", 64'h44, 1'b1, 8'h12, 2'b00);
    r_end("incr_rd");

    // WRAP read: 0x18, 0x00, 0x08, 0x10
    ar_send(8'h34, 64'h8000_0018, 8'd3, BURST_WRAP);
    r_beat("wrap_b0", 64'h44, 1'b0, 8'h34, 2'b00);
    r_beat("wrap_b1", 64'h11, 1'b0, 8'h34, 2'b00);
    r_beat("wrap_b2", 64'h22, 1'b0, 8'h34, 2'b00);
    r_beat("wrap_b3", 64'h33, 1'b1, 8'h34, 2'b00);
    r_end("wrap_rd");

    // Strobe merge and read backpressure
    aw_send(8'h01, 64'h8000_0100, 8'd0, BURST_INCR);
    w_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    b_take("strb_fill", 8'h01, 2'b00);
    aw_send(8'h02, 64'h8000_0100, 8'd0, BURST_INCR);
    w_beat(64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 1'b1);
    b_take("strb_wr", 8'h02, 2'b00);
    req.r_ready = 1'b0;
    ar_send(8'h03, 64'h8000_0100, 8'd0, BURST_INCR);
    for (int i = 0; i < 3; i++) begin
      check("stall_rvalid", resp.r_valid, 1'b1);
      check("stall_rdata", resp.r_data, 64'hFFFF_FFFF_BBBB_BBBB);
      check("stall_rlast", resp.r_last, 1'b1);
      tick();
    end
    req.r_ready = 1'b1;
    r_beat("strb_rd", 64'hFFFF_FFFF_BBBB_BBBB, 1'b1, 8'h03, 2'b00);
    r_end("strb_rd");

    // wlast on the wrong beat
    aw_send(8'h05, 64'h8000_0200, 8'd1, BURST_INCR);
    w_beat(64'h1, 8'hFF, 1'b1);
    w_beat(64'h2, 8'hFF, 1'b0);
    b_take("wlast_err", 8'h05, 2'b10);

    // FIXED burst writes the same word twice
    aw_send(8'h06, 64'h8000_0300, 8'd1, BURST_FIXED);
    w_beat(64'hC1, 8'hFF, 1'b0);
    w_beat(64'hC2, 8'hFF, 1'b1);
    b_take("fixed_wr", 8'h06, 2'b00);
    ar_send(8'h07, 64'h8000_0300, 8'd0, BURST_INCR);
    r_beat("fixed_rd", 64'hC2, 1'b1, 8'h07, 2'b00);
    r_end("fixed_rd");

    // Reset asserted mid-burst
    req.r_ready = 1'b0;
    ar_send(8'h08, 64'h8000_0000, 8'd3, BURST_INCR);
    check("mid_rst_pre_rvalid", resp.r_valid, 1'b1);
    rstn = 1'b0;
    #1;
    check("mid_rst_rvalid", resp.r_valid, 1'b0);
    check("mid_rst_ar_ready", resp.ar_ready, 1'b1);
    @(negedge clk);
    rstn = 1'b1;
    req.r_ready = 1'b1;
    tick();

`ifdef AXI_MEM_RESP_DECERR_EN
    ar_send(8'h09, 64'h0000_1000, 8'd1, BURST_INCR);
    r_beat("decerr_b0", 64'h0, 1'b0, 8'h09, 2'b11);
    r_beat("decerr_b1", 64'h0, 1'b1, 8'h09, 2'b11);
    r_end("decerr_rd");
`else
    // 0x8001_0000 aliases onto word 0
    ar_send(8'h09, 64'h8001_0000, 8'd0, BURST_INCR);
    r_beat("alias_rd", 64'h11, 1'b1, 8'h09, 2'b00);
    r_end("alias_rd");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
